// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings (common with the transmitter)
// and parity_type codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP1_BIT  = 3'd4,
    STOP2_BIT  = 3'd5
  } state_t;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  function automatic logic has_parity(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; flops reset to the
// idle (high) level so reset never looks like a start bit.
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sipo.sv
// UART receiver: oversampled rx line to parallel byte with done strobe and
// error flags. Optional break detector output enabled by SIPO_BREAK_DETECT_EN.
//
// state      | meaning
// IDLE       | waiting for armed falling edge on synchronised rx
// START_BIT  | confirming start bit at its mid-point
// DATA_BITS  | shifting in 7/8 data bits, LSB first
// PARITY_BIT | capturing parity bit
// STOP1_BIT  | first stop bit
// STOP2_BIT  | second stop bit (two-stop mode only)
module sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_length,
  input  logic       stop_bits,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       parity_out,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
`ifdef SIPO_BREAK_DETECT_EN
  output logic       break_det,
`endif
  output logic       framing_error
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);

  state_t      state;
  logic        rx_s;
  logic        armed;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic        len_r, stop_r;
  logic [1:0]  ptype_r;
  logic [7:0]  sh;
  logic        par_r, frm_r;
  logic        sample_pt, last_stop, frm_now, perr;
  logic [2:0]  last_idx;
`ifdef SIPO_BREAK_DETECT_EN
  logic        zero_r;
`endif

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (baud_clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign sample_pt = (state != IDLE) && (cnt == SAMPLE_AT);
  assign last_stop = sample_pt &&
                     ((state == STOP1_BIT && !stop_r) || state == STOP2_BIT);
  assign frm_now   = frm_r | ~rx_s;
  assign last_idx  = len_r ? 3'd7 : 3'd6;

  always_comb begin
    perr = 1'b0;
    case (ptype_r)
      PAR_EVEN: perr = ^{sh, par_r};
      PAR_ODD:  perr = ~(^{sh, par_r});
      default:  perr = 1'b0;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      armed         <= 1'b1;
      len_r         <= 1'b0;
      stop_r        <= 1'b0;
      ptype_r       <= PAR_NONE;
      sh            <= '0;
      par_r         <= 1'b0;
      frm_r         <= 1'b0;
      data_out      <= '0;
      parity_out    <= 1'b0;
      rx_active     <= 1'b0;
      rx_done       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
`ifdef SIPO_BREAK_DETECT_EN
      zero_r        <= 1'b0;
      break_det     <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
`ifdef SIPO_BREAK_DETECT_EN
      break_det <= 1'b0;
`endif
      if (state == IDLE) begin
        if (rx_s) armed <= 1'b1;
        if (armed && !rx_s) begin
          len_r     <= data_length;
          stop_r    <= stop_bits;
          ptype_r   <= parity_type;
          // the detecting cycle itself is sample 0 of the start bit
          cnt       <= CW'(1);
          bit_idx   <= '0;
          sh        <= '0;
          par_r     <= 1'b0;
          frm_r     <= 1'b0;
          rx_active <= 1'b1;
          state     <= START_BIT;
`ifdef SIPO_BREAK_DETECT_EN
          zero_r    <= 1'b1;
`endif
        end
      end else begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (sample_pt) begin
          case (state)
            START_BIT: begin
              if (rx_s) begin
                state     <= IDLE;
                rx_active <= 1'b0;
              end else begin
                state   <= DATA_BITS;
                bit_idx <= '0;
              end
            end
            DATA_BITS: begin
              sh[bit_idx] <= rx_s;
              if (bit_idx == last_idx)
                state <= has_parity(ptype_r) ? PARITY_BIT : STOP1_BIT;
              else
                bit_idx <= bit_idx + 3'd1;
            end
            PARITY_BIT: begin
              par_r <= rx_s;
              state <= STOP1_BIT;
            end
            STOP1_BIT: begin
              frm_r <= frm_now;
              if (stop_r) state <= STOP2_BIT;
            end
            default: ;
          endcase
`ifdef SIPO_BREAK_DETECT_EN
          if (state != START_BIT) zero_r <= zero_r & ~rx_s;
`endif
          if (last_stop) begin
            state         <= IDLE;
            rx_active     <= 1'b0;
            rx_done       <= 1'b1;
            data_out      <= sh;
            parity_out    <= par_r;
            parity_error  <= perr;
            framing_error <= frm_now;
            // a line stuck low must go high before another frame can start
            if (frm_now) armed <= 1'b0;
`ifdef SIPO_BREAK_DETECT_EN
            break_det     <= zero_r & ~rx_s;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed vector table, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_sipo;
  localparam int OS = 16;
  localparam int SY = 2;

  logic       baud_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_length = 1'b1;
  logic       stop_bits = 1'b0;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       parity_out, rx_active, rx_done, parity_error, framing_error;
`ifdef SIPO_BREAK_DETECT_EN
  logic       break_det;
`endif

  sipo #(.OVERSAMPLE(OS), .SYNC_STAGES(SY)) dut (
    .baud_clk      (baud_clk),
    .rst           (rst),
    .rx            (rx),
    .data_length   (data_length),
    .stop_bits     (stop_bits),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .parity_out    (parity_out),
    .rx_active     (rx_active),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
`ifdef SIPO_BREAK_DETECT_EN
    .break_det     (break_det),
`endif
    .framing_error (framing_error)
  );

  always #5 baud_clk = ~baud_clk;

  int tests = 0, fails = 0, cyc = 0, falls = 0, rise_cyc = 0;
  logic prev_act = 1'b0;
  logic [7:0] last_data = 8'h00;

  typedef struct {
    int cyc; int rise; logic [7:0] d; logic p; logic pe; logic fe; logic bk;
  } rec_t;
  rec_t q[$];

  typedef struct {
    logic [7:0] d; bit len; bit stp; logic [1:0] pt; bit pb; bit s1;
    logic [7:0] ed; bit ep; bit epe; bit efe;
  } vec_t;
  vec_t tbl[8];

  always @(posedge baud_clk) cyc++;

  // strobe monitor: records every rx_done with the outputs seen alongside it
  always @(negedge baud_clk) begin
    rec_t r;
    if (rx_active === 1'b1 && prev_act !== 1'b1) rise_cyc = cyc;
    if (prev_act === 1'b1 && rx_active !== 1'b1 && rx_done !== 1'b1) falls++;
    if (rx_done === 1'b1) begin
      r.cyc = cyc; r.rise = rise_cyc; r.d = data_out; r.p = parity_out;
      r.pe = parity_error; r.fe = framing_error;
`ifdef SIPO_BREAK_DETECT_EN
      r.bk = break_det;
`else
      r.bk = 1'b0;
`endif
      q.push_back(r);
    end
    prev_act = rx_active;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit len, input bit stp,
                            input logic [1:0] pt, input bit pb, input bit s1,
                            input bit s2, output int start, output int nb);
    logic bits[13];
    bit hp;
    hp = (pt == 2'b01) || (pt == 2'b10);
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < (len ? 8 : 7); i++) bits[nb++] = d[i];
    if (hp) bits[nb++] = pb;
    bits[nb++] = s1;
    if (stp) bits[nb++] = s2;
    data_length = len; stop_bits = stp; parity_type = pt;
    start = cyc;
    for (int b = 0; b < nb; b++) begin
      rx = bits[b];
      repeat (OS) @(negedge baud_clk);
      if (b == 0) begin
        data_length = 1'($urandom); stop_bits = 1'($urandom);
        parity_type = 2'($urandom);
      end
    end
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] ed, input bit ep,
                              input bit epe, input bit efe, input bit ebk,
                              input int start, input int nb);
    rec_t r;
    int w;
    w = 0;
    while (q.size() == 0 && w < 400) begin
      @(negedge baud_clk);
      w++;
    end
    if (q.size() == 0) begin
      chk({nm, "_strobe"}, 0, 1);
      return;
    end
    r = q.pop_front();
    chk({nm, "_data"}, r.d, ed);
    chk({nm, "_par"}, r.p, ep);
    chk({nm, "_perr"}, r.pe, epe);
    chk({nm, "_ferr"}, r.fe, efe);
    chk({nm, "_time"}, r.cyc, start + SY + OS / 2 + OS * (nb - 1));
    chk({nm, "_rise"}, r.rise, start + SY + 1);
`ifdef SIPO_BREAK_DETECT_EN
    chk({nm, "_brk"}, r.bk, ebk);
`endif
    last_data = ed;
  endtask

  initial begin
    int st, st2, nb, nb2, f0, hi, ones;
    logic [7:0] d, ed;
    bit len, stp, pb, s1, s2, hp, ep, epe, efe, ebk;
    logic [1:0] pt;

    //            d      len stp pt     pb s1  ed     ep epe efe
    tbl[0] = '{8'hA5, 1, 0, 2'b00, 0, 1, 8'hA5, 0, 0, 0};
    tbl[1] = '{8'h55, 0, 1, 2'b10, 0, 1, 8'h55, 0, 0, 0};
    tbl[2] = '{8'h55, 0, 1, 2'b10, 1, 1, 8'h55, 1, 1, 0};
    tbl[3] = '{8'h00, 1, 0, 2'b01, 1, 1, 8'h00, 1, 0, 0};
    tbl[4] = '{8'h3C, 1, 0, 2'b00, 0, 0, 8'h3C, 0, 0, 1};
    tbl[5] = '{8'hFF, 0, 0, 2'b11, 0, 1, 8'h7F, 0, 0, 0};
    tbl[6] = '{8'h01, 1, 0, 2'b10, 0, 1, 8'h01, 0, 1, 0};
    tbl[7] = '{8'h80, 1, 1, 2'b01, 0, 1, 8'h80, 0, 0, 0};

    rst = 1'b1;
    repeat (3) @(negedge baud_clk);
    chk("rst_data", data_out, 0);
    chk("rst_par", parity_out, 0);
    chk("rst_active", rx_active, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ferr", framing_error, 0);
`ifdef SIPO_BREAK_DETECT_EN
    chk("rst_brk", break_det, 0);
`endif
    rst = 1'b0;
    idle(2 * OS);

    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].d, tbl[i].len, tbl[i].stp, tbl[i].pt, tbl[i].pb,
                 tbl[i].s1, 1'b1, st, nb);
      expect_frame($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ep, tbl[i].epe,
                   tbl[i].efe, 1'b0, st, nb);
      idle(2 * OS);
      chk($sformatf("vec%0d_extra", i), q.size(), 0);
    end

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom); len = 1'($urandom); stp = 1'($urandom);
      pt = 2'($urandom); pb = 1'($urandom);
      s1 = ($urandom_range(0, 3) != 0); s2 = ($urandom_range(0, 3) != 0);
      ed = len ? d : {1'b0, d[6:0]};
      hp = (pt == 2'b01) || (pt == 2'b10);
      ep = hp ? pb : 1'b0;
      ones = $countones(ed) + (hp ? int'(pb) : 0);
      epe = hp && ((pt == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0));
      efe = !s1 || (stp && !s2);
      ebk = (ed == 0) && !ep && !s1 && (!stp || !s2);
      send_frame(d, len, stp, pt, pb, s1, s2, st, nb);
      expect_frame($sformatf("rnd%0d", i), ed, ep, epe, efe, ebk, st, nb);
      idle(2 * OS);
    end

    // stop bit low, line stays low: no retrigger until it goes high
    send_frame(8'h96, 1, 0, 2'b00, 0, 0, 1, st, nb);
    expect_frame("ferr", 8'h96, 0, 0, 1, 0, st, nb);
    hi = 0;
    repeat (3 * OS) begin
      @(negedge baud_clk);
      if (rx_active === 1'b1) hi++;
    end
    chk("ferr_no_retrigger", hi, 0);
    idle(2 * OS);
    send_frame(8'h3C, 1, 0, 2'b00, 0, 1, 1, st, nb);
    expect_frame("after_ferr", 8'h3C, 0, 0, 0, 0, st, nb);
    idle(2 * OS);

    // glitch shorter than half a bit
    f0 = falls;
    rx = 1'b0;
    repeat (4) @(negedge baud_clk);
    idle(3 * OS);
    chk("glitch_no_done", q.size(), 0);
    chk("glitch_abort", falls - f0, 1);
    chk("glitch_active", rx_active, 0);
    chk("glitch_data_hold", data_out, last_data);

    // back-to-back frames, no idle gap
    send_frame(8'h12, 1, 0, 2'b00, 0, 1, 1, st, nb);
    send_frame(8'h34, 1, 0, 2'b00, 0, 1, 1, st2, nb2);
    expect_frame("b2b0", 8'h12, 0, 0, 0, 0, st, nb);
    expect_frame("b2b1", 8'h34, 0, 0, 0, 0, st2, nb2);
    idle(2 * OS);

    // reset while in DATA_BITS
    f0 = falls;
    data_length = 1'b1; stop_bits = 1'b0; parity_type = 2'b00;
    rx = 1'b0;
    repeat (OS * 3) @(negedge baud_clk);
    rst = 1'b1;
    @(negedge baud_clk);
    chk("mrst_data", data_out, 0);
    chk("mrst_active", rx_active, 0);
    chk("mrst_done", rx_done, 0);
    chk("mrst_ferr", framing_error, 0);
    rst = 1'b0;
    idle(3 * OS);
    chk("mrst_no_done", q.size(), 0);
    chk("mrst_abort", falls - f0, 1);
    send_frame(8'hFF, 1, 0, 2'b00, 0, 1, 1, st, nb);
    expect_frame("after_rst", 8'hFF, 0, 0, 0, 0, st, nb);
    idle(2 * OS);

`ifdef SIPO_BREAK_DETECT_EN
    // line held low for 20 bit times
    send_frame(8'h00, 1, 0, 2'b00, 0, 0, 0, st, nb);
    expect_frame("break", 8'h00, 0, 0, 1, 1, st, nb);
    rx = 1'b0;
    repeat (10 * OS) @(negedge baud_clk);
    idle(2 * OS);
    chk("break_single", q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
